// File: rtl/multicycle_controller.sv
// Control FSM for the 16-bit multicycle RISC-V core: decodes state and
// instruction fields into datapath enables/selects, with trap and retire debug.
module multicycle_controller #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          op,
  input  logic [2:0]          func3,
  input  logic                funct7,
  input  logic [1:0]          Branch_funct,
  input  logic                zero,
  input  logic                less,
  input  logic                greater,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                memWrite,
  output logic                regWrite,
  output logic                adrSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          resultSrc,
  output logic [2:0]          ALUControl,
  output logic [2:0]          immSrc,
  output logic [3:0]          state_dbg,
  output logic                instr_done,
  output logic                trap,
  output logic [RETIRE_W-1:0] retire_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  state_t state;
  logic   pc_w, ir_w, mem_w, reg_w, done_w, taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      retire_count <= '0;
    end else begin
      if (instr_done) retire_count <= retire_count + 1'b1;
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (op)
            3'b000:  state <= S_EXECR;
            3'b001:  state <= S_EXECI;
            3'b010,
            3'b011:  state <= S_MEMADR;
            3'b100:  state <= S_BRANCH;
            3'b101:  state <= S_JAL;
            3'b110:  state <= S_JALR;
            default: state <= S_LUI;
          endcase
        end
        S_MEMADR:   state <= (op == 3'b010) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  state <= S_MEMWB;
        S_EXECR,
        S_EXECI:    state <= (func3 == 3'b001) ? S_TRAP : S_ALUWB;
        S_JAL:      state <= S_ALUWB;
        S_JALR:     state <= S_JALRPC;
        S_JALRPC:   state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    case (Branch_funct)
      2'b00:   taken = zero;
      2'b01:   taken = ~zero;
      2'b10:   taken = less;
      default: taken = greater;
    endcase
  end

  always_comb begin
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    done_w     = 1'b0;
    adrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    resultSrc  = 2'b00;
    ALUControl = 3'b000;
    case (state)
      S_FETCH: begin
        ir_w = 1'b1; pc_w = 1'b1; ALUSrcB = 2'b10; resultSrc = 2'b10;
      end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  adrSrc = 1'b1;
      S_MEMWB:    begin resultSrc = 2'b01; reg_w = 1'b1; done_w = 1'b1; end
      S_MEMWRITE: begin adrSrc = 1'b1; mem_w = 1'b1; done_w = 1'b1; end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = (func3 == 3'b000 && funct7) ? 3'b001 : func3;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = func3;
      end
      S_ALUWB:    begin reg_w = 1'b1; done_w = 1'b1; end
      S_BRANCH: begin
        ALUSrcA = 2'b10; ALUControl = 3'b001; pc_w = taken; done_w = 1'b1;
      end
      // JAL and JALRPC both write OldPC+2 into ALUOut for the following ALUWB
      S_JAL,
      S_JALRPC:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_w = 1'b1; end
      S_JALR:     begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_LUI:      begin resultSrc = 2'b11; reg_w = 1'b1; done_w = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      3'b011:  immSrc = 3'b001;
      3'b100:  immSrc = 3'b010;
      3'b101:  immSrc = 3'b011;
      3'b111:  immSrc = 3'b100;
      default: immSrc = 3'b000;
    endcase
  end

  assign PCWrite    = pc_w   & ~rst;
  assign IRWrite    = ir_w   & ~rst;
  assign memWrite   = mem_w  & ~rst;
  assign regWrite   = reg_w  & ~rst;
  assign instr_done = done_w & ~rst;
  assign trap       = (state == S_TRAP);
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction expected cycle
// traces are queued by the driver and compared every cycle by a monitor.
module tb_multicycle_controller;

  localparam int RW = 4;

  typedef struct packed {
    logic          pcw, irw, memw, regw, adr;
    logic [1:0]    sa, sb, rs;
    logic [2:0]    alu, imm;
    logic          done, trap;
    logic [RW-1:0] rc;
  } cyc_t;
  localparam int W = $bits(cyc_t);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    op = '0, func3 = '0;
  logic          funct7 = 1'b0;
  logic [1:0]    Branch_funct = '0;
  logic          zero = 1'b0, less = 1'b0, greater = 1'b0;
  logic          PCWrite, IRWrite, memWrite, regWrite, adrSrc;
  logic [1:0]    ALUSrcA, ALUSrcB, resultSrc;
  logic [2:0]    ALUControl, immSrc;
  logic [3:0]    state_dbg;
  logic          instr_done, trap;
  logic [RW-1:0] retire_count;

  logic [W-1:0]  exp_q[$];
  logic [RW-1:0] model_rc = '0;
  int            n_checks = 0;
  int            n_fail = 0;
  cyc_t          act_v, exp_v;

  multicycle_controller #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .funct7(funct7),
    .Branch_funct(Branch_funct), .zero(zero), .less(less), .greater(greater),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .memWrite(memWrite), .regWrite(regWrite),
    .adrSrc(adrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .resultSrc(resultSrc),
    .ALUControl(ALUControl), .immSrc(immSrc), .state_dbg(state_dbg),
    .instr_done(instr_done), .trap(trap), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  function automatic cyc_t mk(input logic pcw, irw, memw, regw, adr,
                              input logic [1:0] sa, sb, rs,
                              input logic [2:0] alu, input logic done);
    cyc_t c;
    c = '0;
    c.pcw = pcw; c.irw = irw; c.memw = memw; c.regw = regw; c.adr = adr;
    c.sa = sa; c.sb = sb; c.rs = rs; c.alu = alu; c.done = done;
    return c;
  endfunction

  function automatic logic [2:0] imm_of(input logic [2:0] o);
    case (o)
      3'd3:    return 3'd1;
      3'd4:    return 3'd2;
      3'd5:    return 3'd3;
      3'd7:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called one step after a rising edge that begins a FETCH cycle.
  task automatic issue(input logic [2:0] o, input logic [2:0] f3, input logic f7,
                       input logic [1:0] bf, input logic z, l, g,
                       input int trap_cycles, input int stop_after);
    cyc_t seq[$];
    cyc_t t;
    logic taken;
    logic completes;
    op = o; func3 = f3; funct7 = f7; Branch_funct = bf;
    zero = z; less = l; greater = g;
    completes = 1'b1;
    seq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 3'd0, 1'b0));
    seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'd0, 1'b0));
    case (o)
      3'd0, 3'd1: begin
        seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, (o == 3'd1) ? 2'd1 : 2'd0, 2'd0,
                         (o == 3'd0 && f3 == 3'd0 && f7) ? 3'd1 : f3, 1'b0));
        if (f3 == 3'd1) begin
          completes = 1'b0;
          for (int i = 0; i < trap_cycles; i++) begin
            t = '0; t.trap = 1'b1; seq.push_back(t);
          end
        end else
          seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1));
      end
      3'd2: begin
        seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 3'd0, 1'b0));
        seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0));
        seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd1, 3'd0, 1'b1));
      end
      3'd3: begin
        seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 3'd0, 1'b0));
        seq.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1));
      end
      3'd4: begin
        taken = (bf == 2'd0) ? z : (bf == 2'd1) ? ~z : (bf == 2'd2) ? l : g;
        seq.push_back(mk(taken, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 3'd1, 1'b1));
      end
      3'd5: begin
        seq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd0, 3'd0, 1'b0));
        seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1));
      end
      3'd6: begin
        seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 3'd0, 1'b0));
        seq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd0, 3'd0, 1'b0));
        seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1));
      end
      default:
        seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd3, 3'd0, 1'b1));
    endcase
    if (stop_after > 0) begin
      while (seq.size() > stop_after) void'(seq.pop_back());
      completes = 1'b0;
    end
    foreach (seq[i]) begin
      seq[i].imm = imm_of(o);
      seq[i].rc  = model_rc;
      exp_q.push_back(seq[i]);
    end
    if (completes) model_rc = model_rc + 1'b1;
    repeat (seq.size()) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op = '0; func3 = '0; funct7 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {28'd0, state_dbg}, 32'd0);
    check("rst_enables", {28'd0, PCWrite, IRWrite, memWrite, regWrite}, 32'd0);
    check("rst_done_trap", {30'd0, instr_done, trap}, 32'd0);
    check("rst_retire", {{(32-RW){1'b0}}, retire_count}, 32'd0);
    check("rst_queue_empty", exp_q.size(), 32'd0);
    model_rc = '0;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      act_v = '0;
      act_v.pcw = PCWrite; act_v.irw = IRWrite; act_v.memw = memWrite;
      act_v.regw = regWrite; act_v.adr = adrSrc; act_v.sa = ALUSrcA;
      act_v.sb = ALUSrcB; act_v.rs = resultSrc; act_v.alu = ALUControl;
      act_v.imm = immSrc; act_v.done = instr_done; act_v.trap = trap;
      act_v.rc = retire_count;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_cycle: got %h expected nothing at %0t", act_v, $time);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL cycle_vec: got %h expected %h at %0t (op=%0d func3=%0d)",
                   act_v, exp_v, $time, op, func3);
        end
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [2:0] o, f3;
    do_reset();
    // directed cases
    issue(3'd0, 3'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // sub
    issue(3'd2, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // load
    issue(3'd3, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // store
    issue(3'd4, 3'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 0, 0);   // bne, not taken
    issue(3'd4, 3'd0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 0, 0);   // blt, taken
    issue(3'd4, 3'd0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 0, 0);   // bgt, taken
    issue(3'd5, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // jal
    issue(3'd6, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // jalr
    issue(3'd7, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // lui
    issue(3'd1, 3'd7, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 0, 0);   // I-ALU srl, funct7 ignored
    issue(3'd1, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 10, 0);  // illegal -> trap
    do_reset();
    issue(3'd2, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0, 3);   // load aborted by reset
    do_reset();
    for (int n = 0; n < 150; n++) begin
      o  = 3'($urandom_range(0, 7));
      f3 = 3'($urandom_range(0, 7));
      if ((o == 3'd0 || o == 3'd1) && f3 == 3'd1) f3 = 3'd0;
      issue(o, f3, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    end
    issue(3'd0, 3'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 10, 0);  // illegal R-ALU -> trap
    do_reset();
    issue(3'd7, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
